// File: rtl/cenn_pkg.sv
// Shared state encoding and default sizing for the CeNN iteration sequencer
// and the datapath instance it drives.
package cenn_pkg;

    localparam int CENN_WIDTH    = 8;
    localparam int CENN_ADDR_W   = 10;
    localparam int CENN_N_PIX    = 1024;
    localparam int CENN_ITER_W   = 8;
    localparam int CENN_PIPE_LAT = 5;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        DRAIN,
        SWAP,
        DONE
    } cenn_state_t;

endpackage

// File: rtl/cenn_wr_delay.sv
// Write-back delay line: carries each read beat's {valid, addr} forward by
// PIPE_LAT cycles so the write lands when the datapath result for it is ready.
module cenn_wr_delay
    import cenn_pkg::*;
#(
    parameter int ADDR_W   = CENN_ADDR_W,
    parameter int PIPE_LAT = CENN_PIPE_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              abort,
    input  logic              beat_valid,
    input  logic [ADDR_W-1:0] beat_addr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr
);

    logic [PIPE_LAT-1:0] valid_sr;
    logic [ADDR_W-1:0]   addr_sr [PIPE_LAT];

    // Abort flushes in-flight beats so no partial iteration is written back.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            valid_sr <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                addr_sr[i] <= '0;
            end
        end else begin
            valid_sr[0] <= beat_valid;
            addr_sr[0]  <= beat_addr;
            for (int i = 1; i < PIPE_LAT; i++) begin
                valid_sr[i] <= valid_sr[i-1];
                addr_sr[i]  <= addr_sr[i-1];
            end
        end
    end

    assign wr_en   = valid_sr[PIPE_LAT-1];
    assign wr_addr = addr_sr[PIPE_LAT-1];

endmodule

// File: rtl/cenn_iter_ctrl.sv
// Iteration sequencer: streams the state image through the CeNN datapath and
// writes results back to the opposite ping-pong bank, once per iteration.
module cenn_iter_ctrl
    import cenn_pkg::*;
#(
    parameter int WIDTH    = CENN_WIDTH,
    parameter int ADDR_W   = CENN_ADDR_W,
    parameter int N_PIX    = CENN_N_PIX,
    parameter int ITER_W   = CENN_ITER_W,
    parameter int PIPE_LAT = CENN_PIPE_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ITER_W-1:0] n_iter,
    output logic              read_ready,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              bank_sel,
    output logic [ITER_W-1:0] iter_cnt,
    output logic              busy,
    output logic              done
);

    localparam int                 DRAIN_W    = $clog2(PIPE_LAT + 1);
    localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(N_PIX - 1);
    localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(PIPE_LAT - 1);

    if (N_PIX < 2 || N_PIX > (1 << ADDR_W) || PIPE_LAT < 1 || WIDTH < 1) begin : g_bad_params
        $error("cenn_iter_ctrl: illegal parameter combination");
    end

    cenn_state_t         state;
    cenn_state_t         state_nxt;
    logic [ADDR_W-1:0]   rd_addr_nxt;
    logic [DRAIN_W-1:0]  drain_cnt;
    logic [DRAIN_W-1:0]  drain_cnt_nxt;
    logic [ITER_W-1:0]   iter_tgt;
    logic [ITER_W-1:0]   iter_tgt_nxt;
    logic [ITER_W-1:0]   iter_cnt_nxt;
    logic [ITER_W-1:0]   iter_inc;
    logic                bank_sel_nxt;
    logic                beat_valid;
    logic [ADDR_W-1:0]   beat_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-value logic; every output is registered from these.
    always_comb begin
        state_nxt     = state;
        rd_addr_nxt   = rd_addr;
        drain_cnt_nxt = drain_cnt;
        iter_tgt_nxt  = iter_tgt;
        iter_cnt_nxt  = iter_cnt;
        bank_sel_nxt  = bank_sel;
        iter_inc      = iter_cnt + ITER_W'(1);

        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nxt     = FILL;
                    iter_tgt_nxt  = (n_iter == '0) ? ITER_W'(1) : n_iter;
                    iter_cnt_nxt  = '0;
                    rd_addr_nxt   = '0;
                    drain_cnt_nxt = '0;
                end
            end
            FILL: begin
                if (rd_addr == LAST_ADDR) begin
                    state_nxt     = DRAIN;
                    drain_cnt_nxt = '0;
                end else begin
                    rd_addr_nxt = rd_addr + ADDR_W'(1);
                end
            end
            DRAIN: begin
                if (drain_cnt == LAST_DRAIN) begin
                    state_nxt = SWAP;
                end else begin
                    drain_cnt_nxt = drain_cnt + DRAIN_W'(1);
                end
            end
            SWAP: begin
                bank_sel_nxt = ~bank_sel;
                rd_addr_nxt  = '0;
                if (iter_cnt != iter_tgt) begin
                    iter_cnt_nxt = iter_inc;
                end
                state_nxt = (iter_cnt_nxt == iter_tgt) ? DONE : FILL;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Cancel keeps the bank/iteration bookkeeping of the last swap that completed.
        if (abort && state != IDLE) begin
            state_nxt     = IDLE;
            rd_addr_nxt   = '0;
            drain_cnt_nxt = '0;
            iter_cnt_nxt  = iter_cnt;
            bank_sel_nxt  = bank_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr    <= '0;
            drain_cnt  <= '0;
            iter_tgt   <= '0;
            iter_cnt   <= '0;
            bank_sel   <= 1'b0;
            read_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            rd_addr    <= rd_addr_nxt;
            drain_cnt  <= drain_cnt_nxt;
            iter_tgt   <= iter_tgt_nxt;
            iter_cnt   <= iter_cnt_nxt;
            bank_sel   <= bank_sel_nxt;
            read_ready <= (state_nxt == FILL) || (state_nxt == DRAIN);
            busy       <= (state_nxt != IDLE);
            done       <= (state_nxt == DONE);
        end
    end

    // Only FILL beats carry real pixels; DRAIN beats enter the delay line as bubbles.
    assign beat_valid = (state == FILL);
    assign beat_addr  = beat_valid ? rd_addr : '0;

    cenn_wr_delay #(
        .ADDR_W   (ADDR_W),
        .PIPE_LAT (PIPE_LAT)
    ) u_wr_delay (
        .clk        (clk),
        .rst        (rst),
        .abort      (abort),
        .beat_valid (beat_valid),
        .beat_addr  (beat_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr)
    );

endmodule

// File: tb/tb_cenn_iter_ctrl.sv
// Self-checking bench for cenn_iter_ctrl: directed scenarios plus randomized
// runs, each cycle compared against an arithmetic model of the iteration timeline.
module tb_cenn_iter_ctrl;

    localparam int WIDTH    = 8;
    localparam int ADDR_W   = 4;
    localparam int N_PIX    = 16;
    localparam int ITER_W   = 8;
    localparam int PIPE_LAT = 5;
    localparam int P        = N_PIX + PIPE_LAT + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [ITER_W-1:0] n_iter;
    logic              read_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              bank_sel;
    logic [ITER_W-1:0] iter_cnt;
    logic              busy;
    logic              done;

    typedef struct {
        bit rr;
        int rd;
        bit wr;
        int wa;
        bit bank;
        int iter;
        bit busy;
        bit done;
    } exp_t;

    int checks = 0;
    int errors = 0;
    bit model_bank;
    int model_iter;
    int beats;
    int writes;
    int dones;

    cenn_iter_ctrl #(
        .WIDTH    (WIDTH),
        .ADDR_W   (ADDR_W),
        .N_PIX    (N_PIX),
        .ITER_W   (ITER_W),
        .PIPE_LAT (PIPE_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .n_iter     (n_iter),
        .read_ready (read_ready),
        .rd_addr    (rd_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .bank_sel   (bank_sel),
        .iter_cnt   (iter_cnt),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic exp_t zeroExp();
        exp_t e;
        e.rr = 0; e.rd = 0; e.wr = 0; e.wa = 0;
        e.bank = 0; e.iter = 0; e.busy = 0; e.done = 0;
        return e;
    endfunction

    // Timeline model: relative cycle r (r=1 is the first cycle after start),
    // each iteration is N_PIX+PIPE_LAT beats then one swap cycle.
    function automatic exp_t predict(input int r, input int n, input bit b0);
        exp_t e;
        int last;
        int j;
        int o;
        e = zeroExp();
        last = n * P + 1;
        if (r >= last) begin
            e.bank = b0 ^ n[0];
            e.iter = n;
            e.busy = (r == last);
            e.done = (r == last);
        end else begin
            j = (r - 1) / P;
            o = (r - 1) % P;
            e.busy = 1'b1;
            e.iter = j;
            e.bank = b0 ^ j[0];
            if (o < N_PIX + PIPE_LAT) begin
                e.rr = 1'b1;
                e.rd = (o < N_PIX) ? o : N_PIX - 1;
                e.wr = (o >= PIPE_LAT);
                e.wa = o - PIPE_LAT;
            end
        end
        return e;
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic checkOutput(input exp_t e, input int r);
        checkVal($sformatf("r%0d read_ready", r), 32'(read_ready), 32'(e.rr));
        checkVal($sformatf("r%0d wr_en", r), 32'(wr_en), 32'(e.wr));
        checkVal($sformatf("r%0d bank_sel", r), 32'(bank_sel), 32'(e.bank));
        checkVal($sformatf("r%0d iter_cnt", r), 32'(iter_cnt), e.iter);
        checkVal($sformatf("r%0d busy", r), 32'(busy), 32'(e.busy));
        checkVal($sformatf("r%0d done", r), 32'(done), 32'(e.done));
        if (e.rr) checkVal($sformatf("r%0d rd_addr", r), 32'(rd_addr), e.rd);
        if (e.wr) checkVal($sformatf("r%0d wr_addr", r), 32'(wr_addr), e.wa);
        if (read_ready === 1'b1) beats++;
        if (wr_en === 1'b1) writes++;
        if (done === 1'b1) dones++;
    endtask

    task automatic checkIdleZero(input int r);
        checkOutput(zeroExp(), r);
        checkVal($sformatf("r%0d reset rd_addr", r), 32'(rd_addr), 0);
        checkVal($sformatf("r%0d reset wr_addr", r), 32'(wr_addr), 0);
    endtask

    task automatic doReset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; n_iter = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_bank = 1'b0;
        model_iter = 0;
    endtask

    task automatic idleCycles(input int k);
        exp_t e;
        e = zeroExp();
        e.bank = model_bank;
        e.iter = model_iter;
        start = 1'b0; abort = 1'b0; rst = 1'b0;
        for (int i = 0; i < k; i++) begin
            checkOutput(e, -1);
            @(posedge clk);
            #1;
        end
    endtask

    // One run: start with n_raw, optionally abort / reset / re-pulse start at
    // given relative cycles (-1 = never), checking every cycle against the model.
    task automatic applyStimulus(input int n_raw, input int abort_at, input int rst_at,
                                 input int restart_at);
        int   n;
        int   cut;
        bit   cut_rst;
        int   end_r;
        int   r;
        bit   b0;
        exp_t e;
        exp_t held;
        n = (n_raw == 0) ? 1 : n_raw;
        cut = -1;
        cut_rst = 1'b0;
        b0 = model_bank;
        held = zeroExp();
        beats = 0; writes = 0; dones = 0;
        n_iter = ITER_W'(n_raw);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_iter = ITER_W'($urandom);
        end_r = n * P + 3;
        r = 1;
        while (r <= end_r) begin
            if (cut < 0) begin
                e = predict(r, n, b0);
            end else if (cut_rst) begin
                e = zeroExp();
            end else begin
                e = held;
                e.rr = 0; e.wr = 0; e.busy = 0; e.done = 0;
            end
            checkOutput(e, r);
            rst = 1'b0; abort = 1'b0; start = 1'b0;
            if (r == abort_at) begin
                abort = 1'b1; cut = r; held = e; end_r = r + 5;
            end
            if (r == rst_at) begin
                rst = 1'b1; cut = r; cut_rst = 1'b1; end_r = r + 5;
            end
            if (r == restart_at) begin
                start = 1'b1;
                n_iter = ITER_W'(n_raw + 1 + int'($urandom_range(0, 3)));
            end
            @(posedge clk);
            #1;
            r++;
        end
        rst = 1'b0; abort = 1'b0; start = 1'b0;
        model_bank = e.bank;
        model_iter = e.iter;
    endtask

    initial begin
        int n_raw;
        int choice;
        int ab;
        int rs;
        rst = 1'b1; start = 1'b0; abort = 1'b0; n_iter = '0;

        // Reset and idle, then start while reset is held.
        doReset();
        for (int i = 0; i < 10; i++) begin
            checkIdleZero(i);
            @(posedge clk);
            #1;
        end
        rst = 1'b1; start = 1'b1; n_iter = 8'd4;
        @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkIdleZero(100 + i);
            @(posedge clk);
            #1;
        end

        // Single iteration.
        applyStimulus(1, -1, -1, -1);
        checkVal("n1 beats", beats, N_PIX + PIPE_LAT);
        checkVal("n1 writes", writes, N_PIX);
        checkVal("n1 done pulses", dones, 1);
        checkVal("n1 bank_sel", 32'(bank_sel), 1);
        checkVal("n1 iter_cnt", 32'(iter_cnt), 1);
        idleCycles(2);

        // Three iterations from a fresh reset.
        doReset();
        applyStimulus(3, -1, -1, -1);
        checkVal("n3 beats", beats, 3 * (N_PIX + PIPE_LAT));
        checkVal("n3 writes", writes, 3 * N_PIX);
        checkVal("n3 done pulses", dones, 1);
        checkVal("n3 bank_sel", 32'(bank_sel), 1);
        checkVal("n3 iter_cnt", 32'(iter_cnt), 3);

        // Zero iterations behaves as one.
        doReset();
        applyStimulus(0, -1, -1, -1);
        checkVal("n0 beats", beats, N_PIX + PIPE_LAT);
        checkVal("n0 writes", writes, N_PIX);
        checkVal("n0 done pulses", dones, 1);
        checkVal("n0 iter_cnt", 32'(iter_cnt), 1);

        // Abort at rd_addr 7 of iteration 2 of 3, then a clean rerun.
        doReset();
        applyStimulus(3, 1 + P + 7, -1, -1);
        checkVal("abort done pulses", dones, 0);
        checkVal("abort bank_sel", 32'(bank_sel), 1);
        checkVal("abort iter_cnt", 32'(iter_cnt), 1);
        checkVal("abort busy", 32'(busy), 0);
        idleCycles(2);
        applyStimulus(2, -1, -1, -1);
        checkVal("rerun writes", writes, 2 * N_PIX);

        // Start re-pulsed during FILL is ignored.
        applyStimulus(2, -1, -1, 5);
        checkVal("restart ignored writes", writes, 2 * N_PIX);
        checkVal("restart ignored dones", dones, 1);

        // Reset during DRAIN.
        applyStimulus(1, -1, N_PIX + 2, -1);
        checkVal("rst drain done pulses", dones, 0);

        // Abort together with start in IDLE.
        start = 1'b1; abort = 1'b1; n_iter = 8'd2;
        @(posedge clk);
        #1;
        start = 1'b0; abort = 1'b0;
        idleCycles(3);

        // Randomized runs.
        for (int k = 0; k < 10; k++) begin
            n_raw  = int'($urandom_range(0, 4));
            choice = int'($urandom_range(0, 3));
            ab = -1;
            rs = -1;
            if (choice == 0) begin
                ab = int'($urandom_range(1, ((n_raw == 0) ? 1 : n_raw) * P + 1));
            end else if (choice == 1) begin
                rs = int'($urandom_range(2, ((n_raw == 0) ? 1 : n_raw) * P));
            end
            applyStimulus(n_raw, ab, -1, rs);
            idleCycles(int'($urandom_range(1, 4)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
